// File: rtl/i2s_tx.sv
// i2s_tx: I2S transmitter with a one-entry holding buffer for stereo pairs.
// Each frame is 2*AUDIO_DW sclk cycles long. Left is sent while lrclk=0 and
// right while lrclk=1, MSB first. sdata lags lrclk by one cycle (I2S
// alignment). A frame is loaded on the edge that enters cnt=0. If no pair is
// buffered at that edge, zeros are sent and underrun pulses for one cycle.
module i2s_tx #(
    parameter int AUDIO_DW = 32
) (
    input  logic                sclk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [AUDIO_DW-1:0] s_left,
    input  logic [AUDIO_DW-1:0] s_right,
    input  logic                s_valid,
    output logic                s_ready,
    output logic                lrclk,
    output logic                sdata,
    output logic                underrun,
    output logic                busy
);

    localparam int                FRAME_LEN = 2 * AUDIO_DW;
    localparam int                CNT_W     = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(AUDIO_DW);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic                  buf_full_reg, buf_full_next;
    logic [AUDIO_DW-1:0]   buf_left_reg, buf_left_next;
    logic [AUDIO_DW-1:0]   buf_right_reg, buf_right_next;
    // Frame register: {left, right}. It is shifted left once per RUN cycle,
    // so its MSB is always the next bit to put on sdata.
    logic [FRAME_LEN-1:0]  frame_reg, frame_next;
    logic                  s_ready_reg, s_ready_next;
    logic                  lrclk_reg, lrclk_next;
    logic                  sdata_reg, sdata_next;
    logic                  underrun_reg, underrun_next;
    logic                  busy_reg, busy_next;

    logic                  accept;
    logic                  load;
    logic                  load_from_idle;
    logic [FRAME_LEN-1:0]  frame_shifted;

    // The frame register shifted by one position. A zero enters at the
    // bottom, so the register is all zeros once the whole frame has been sent.
    assign frame_shifted[0] = 1'b0;
    for (genvar gi = 1; gi < FRAME_LEN; gi++) begin : g_shift
        assign frame_shifted[gi] = frame_reg[gi-1];
    end

    // State, counter, buffer, frame register and the registered outputs.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            buf_full_reg  <= 1'b0;
            buf_left_reg  <= '0;
            buf_right_reg <= '0;
            frame_reg     <= '0;
            s_ready_reg   <= 1'b1;
            lrclk_reg     <= 1'b0;
            sdata_reg     <= 1'b0;
            underrun_reg  <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            buf_full_reg  <= buf_full_next;
            buf_left_reg  <= buf_left_next;
            buf_right_reg <= buf_right_next;
            frame_reg     <= frame_next;
            s_ready_reg   <= s_ready_next;
            lrclk_reg     <= lrclk_next;
            sdata_reg     <= sdata_next;
            underrun_reg  <= underrun_next;
            busy_reg      <= busy_next;
        end
    end

    // Next state, frame sequencing, buffer handshake and output values for
    // the cycle that follows the coming edge.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        buf_full_next  = buf_full_reg;
        buf_left_next  = buf_left_reg;
        buf_right_next = buf_right_reg;
        frame_next     = frame_reg;
        sdata_next     = 1'b0;
        underrun_next  = 1'b0;
        load           = 1'b0;
        load_from_idle = 1'b0;
        // s_ready_reg is 0 whenever the buffer is full. This means an accept
        // can never coincide with a load that empties the buffer.
        accept         = s_valid && s_ready_reg;

        // Sequencing. en only matters in IDLE and on the last cycle of a
        // frame, so dropping it mid-frame lets the frame finish.
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (en) begin
                    state_next     = ST_RUN;
                    load           = 1'b1;
                    load_from_idle = 1'b1;
                end
            end
            ST_RUN: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
                    if (en) begin
                        load = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase

        // Data path. On a wrap load, the old frame's right LSB is still at
        // the MSB and goes out at cnt=0. On a start from IDLE, cnt=0 sends 0.
        // The edge that leaves RUN also sends that final right LSB.
        if (load) begin
            frame_next    = buf_full_reg ? {buf_left_reg, buf_right_reg} : '0;
            buf_full_next = 1'b0;
            underrun_next = !buf_full_reg;
            sdata_next    = load_from_idle ? 1'b0 : frame_reg[FRAME_LEN-1];
        end else if (state_reg == ST_RUN) begin
            frame_next = frame_shifted;
            sdata_next = frame_reg[FRAME_LEN-1];
        end

        // The buffer accepts a pair in IDLE as well as in RUN.
        if (accept) begin
            buf_full_next  = 1'b1;
            buf_left_next  = s_left;
            buf_right_next = s_right;
        end

        s_ready_next = !buf_full_next;
        busy_next    = (state_next == ST_RUN);
        lrclk_next   = (state_next == ST_RUN) && (cnt_next >= CNT_HALF);
    end

    assign s_ready  = s_ready_reg;
    assign lrclk    = lrclk_reg;
    assign sdata    = sdata_reg;
    assign underrun = underrun_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: self-checking bench for i2s_tx with AUDIO_DW=4. A behavioural
// model works out the expected outputs from the frame rules (bit position
// within the frame, pair held in the buffer). A small I2S receiver decodes
// the serial stream back into pairs for the loopback check.
module tb_i2s_tx;

    localparam int W  = 4;
    localparam int FR = 2 * W;

    logic         sclk;
    logic         rst_n;
    logic         en;
    logic [W-1:0] s_left;
    logic [W-1:0] s_right;
    logic         s_valid;
    logic         s_ready;
    logic         lrclk;
    logic         sdata;
    logic         underrun;
    logic         busy;

    int vectors;
    int miscompares;

    // Reference model state
    bit            m_run;
    int            m_cnt;
    bit            m_full;
    bit            m_acc;
    logic [W-1:0]  m_bl, m_br, m_fl, m_fr;
    logic          exp_lrclk, exp_sdata, exp_ready, exp_underrun, exp_busy;
    logic [FR-1:0] load_q[$];

    i2s_tx #(.AUDIO_DW(W)) dut (
        .sclk     (sclk),
        .rst_n    (rst_n),
        .en       (en),
        .s_left   (s_left),
        .s_right  (s_right),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .lrclk    (lrclk),
        .sdata    (sdata),
        .underrun (underrun),
        .busy     (busy)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [4:0] dut_vec();
        return {lrclk, sdata, s_ready, underrun, busy};
    endfunction

    function automatic logic [4:0] exp_vec();
        return {exp_lrclk, exp_sdata, exp_ready, exp_underrun, exp_busy};
    endfunction

    task automatic m_reset();
        m_run = 0; m_cnt = 0; m_full = 0; m_acc = 0;
        m_bl = '0; m_br = '0; m_fl = '0; m_fr = '0;
        exp_lrclk = 0; exp_sdata = 0; exp_ready = 1; exp_underrun = 0; exp_busy = 0;
        load_q.delete();
    endtask

    task automatic m_load(input bit from_idle);
        exp_underrun = !m_full;
        exp_sdata    = from_idle ? 1'b0 : m_fr[0];
        if (m_full) begin
            m_fl = m_bl; m_fr = m_br;
        end else begin
            m_fl = '0; m_fr = '0;
        end
        m_full = 0;
        load_q.push_back({m_fl, m_fr});
    endtask

    // One sclk edge of the model. Position m_cnt in the frame selects
    // left[W-k] for k=1..W and right[2W-k] for k=W+1..2W-1.
    task automatic model_edge();
        m_acc = s_valid && !m_full;
        exp_underrun = 0;
        exp_sdata = 0;
        if (!m_run) begin
            m_cnt = 0;
            if (en) begin
                m_load(1'b1);
                m_run = 1;
            end
        end else if (m_cnt == FR - 1) begin
            m_cnt = 0;
            if (en) begin
                m_load(1'b0);
            end else begin
                m_run = 0;
                exp_sdata = m_fr[0];
            end
        end else begin
            m_cnt++;
            if (m_cnt <= W) exp_sdata = m_fl[W - m_cnt];
            else            exp_sdata = m_fr[FR - m_cnt];
        end
        if (m_acc) begin
            m_full = 1; m_bl = s_left; m_br = s_right;
        end
        exp_lrclk = m_run && (m_cnt >= W);
        exp_busy  = m_run;
        exp_ready = !m_full;
    endtask

    task automatic step();
        @(posedge sclk);
        model_edge();
        #1;
    endtask

    task automatic drain();
        en = 0;
        s_valid = 0;
        for (int i = 0; i < 3 * FR && m_run; i++) step();
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1;
        #1;
        rst_n = 0;
        #1;
        vectors++;
        if (dut_vec() !== 5'b00100) begin
            miscompares++;
            $display("FAIL reset_async: got %b expected %b", dut_vec(), 5'b00100);
        end
        m_reset();
        @(posedge sclk);
        #1;
        vectors++;
        if (dut_vec() !== 5'b00100) begin
            miscompares++;
            $display("FAIL reset_hold: got %b expected %b", dut_vec(), 5'b00100);
        end
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_idle: got %b expected %b", dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_basic();
        logic [7:0] lr_pat;
        logic [7:0] sd_pat;
        lr_pat = 8'hF0;
        sd_pat = 8'h4A;
        s_left = 4'hA; s_right = 4'h5; s_valid = 1;
        step();
        s_valid = 0;
        vectors++;
        if (s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_buffer_full: s_ready got %b expected 0", s_ready);
        end
        en = 1;
        step();
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (lrclk !== lr_pat[i]) begin
                miscompares++;
                $display("FAIL basic_lrclk cnt=%0d: got %b expected %b", i, lrclk, lr_pat[i]);
            end
            vectors++;
            if (sdata !== sd_pat[i]) begin
                miscompares++;
                $display("FAIL basic_sdata cnt=%0d: got %b expected %b", i, sdata, sd_pat[i]);
            end
            step();
        end
        vectors++;
        if (sdata !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_next_lsb: got %b expected 1", sdata);
        end
        vectors++;
        if (underrun !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_next_underrun: got %b expected 1", underrun);
        end
        drain();
    endtask

    task automatic test_underrun();
        en = 1;
        step();
        en = 0;
        for (int i = 0; i < FR; i++) begin
            vectors++;
            if (underrun !== (i == 0)) begin
                miscompares++;
                $display("FAIL underrun_pulse cnt=%0d: got %b expected %b", i, underrun, (i == 0));
            end
            vectors++;
            if (sdata !== 1'b0 || s_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL underrun_data cnt=%0d: sdata/s_ready got %b%b expected 01", i, sdata, s_ready);
            end
            step();
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL underrun_stop: busy got %b expected 0", busy);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]  pl[6];
        logic [W-1:0]  pr[6];
        logic [FR-1:0] word;
        int idx;
        int f;
        for (int i = 0; i < 6; i++) begin
            pl[i] = W'($urandom);
            pr[i] = W'($urandom);
        end
        idx = 0; f = 0; word = '0;
        s_left = pl[0]; s_right = pr[0]; s_valid = 1;
        step();
        if (m_acc) begin
            idx++;
            s_left = pl[idx]; s_right = pr[idx];
        end
        en = 1;
        for (int c = 0; c <= 4 * FR; c++) begin
            step();
            if (m_acc) begin
                idx++;
                if (idx < 6) begin
                    s_left = pl[idx]; s_right = pr[idx];
                end else begin
                    s_valid = 0;
                end
            end
            if (c > 0) word = {word[FR-2:0], sdata};
            vectors++;
            if (underrun !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_underrun c=%0d: got %b expected 0", c, underrun);
            end
            if (c % FR == 0) begin
                vectors++;
                if (s_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_ready_rise c=%0d: got %b expected 1", c, s_ready);
                end
                if (c > 0) begin
                    vectors++;
                    if (word !== {pl[f], pr[f]}) begin
                        miscompares++;
                        $display("FAIL b2b_frame %0d: got %h expected %h", f, word, {pl[f], pr[f]});
                    end
                    f++;
                end
            end else if (c % FR == FR - 1) begin
                vectors++;
                if (s_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_ready_full c=%0d: got %b expected 0", c, s_ready);
                end
            end
        end
        drain();
    endtask

    task automatic test_stop();
        logic [W-1:0] pl;
        logic [W-1:0] pr;
        for (int rep = 0; rep < 2; rep++) begin
            pl = W'($urandom);
            pr = W'($urandom);
            pr[0] = 1'(rep);
            s_left = pl; s_right = pr; s_valid = 1;
            step();
            s_valid = 0;
            en = 1;
            step();
            step();
            step();
            en = 0;
            for (int i = 0; i < FR - 3; i++) step();
            vectors++;
            if (lrclk !== 1'b1 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL stop_last_cycle: lrclk/busy got %b%b expected 11", lrclk, busy);
            end
            step();
            vectors++;
            if ({lrclk, sdata, busy} !== {1'b0, pr[0], 1'b0}) begin
                miscompares++;
                $display("FAIL stop_first_idle: lrclk/sdata/busy got %b expected %b",
                         {lrclk, sdata, busy}, {1'b0, pr[0], 1'b0});
            end
            for (int i = 0; i < 2; i++) begin
                step();
                vectors++;
                if ({lrclk, sdata, busy} !== 3'b000) begin
                    miscompares++;
                    $display("FAIL stop_idle_quiet: lrclk/sdata/busy got %b expected 000", {lrclk, sdata, busy});
                end
            end
        end
    endtask

    task automatic test_async_reset();
        s_left = W'($urandom); s_right = W'($urandom); s_valid = 1;
        step();
        en = 1;
        s_valid = 0;
        step();
        s_left = W'($urandom); s_right = W'($urandom); s_valid = 1;
        step();
        s_valid = 0;
        for (int i = 0; i < 4; i++) step();
        vectors++;
        if (s_ready !== 1'b0 || lrclk !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_setup: s_ready/lrclk got %b%b expected 01", s_ready, lrclk);
        end
        #2;
        rst_n = 0;
        #1;
        vectors++;
        if (dut_vec() !== 5'b00100) begin
            miscompares++;
            $display("FAIL arst_immediate: got %b expected %b", dut_vec(), 5'b00100);
        end
        m_reset();
        en = 0;
        @(posedge sclk);
        #1;
        rst_n = 1;
        en = 1;
        step();
        vectors++;
        if ({underrun, sdata, busy} !== 3'b101) begin
            miscompares++;
            $display("FAIL arst_restart: underrun/sdata/busy got %b expected 101", {underrun, sdata, busy});
        end
        drain();
    endtask

    task automatic test_random_loopback();
        logic [FR-1:0] rx;
        logic [FR-1:0] want;
        logic          prev_lr;
        load_q.delete();
        rx = '0;
        prev_lr = 1'b0;
        for (int c = 0; c < 700; c++) begin
            en      = (c < 680) ? ($urandom_range(0, 9) != 0) : 1'b0;
            s_valid = 1'($urandom_range(0, 1));
            s_left  = W'($urandom);
            s_right = W'($urandom);
            step();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random_outputs c=%0d: got %b expected %b", c, dut_vec(), exp_vec());
            end
            rx = {rx[FR-2:0], sdata};
            if (prev_lr === 1'b1 && lrclk === 1'b0) begin
                vectors++;
                if (load_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL loopback_extra_frame c=%0d: got %h expected none", c, rx);
                end else begin
                    want = load_q.pop_front();
                    if (rx !== want) begin
                        miscompares++;
                        $display("FAIL loopback_pair c=%0d: got %h expected %h", c, rx, want);
                    end
                end
            end
            prev_lr = lrclk;
        end
        vectors++;
        if (load_q.size() != 0) begin
            miscompares++;
            $display("FAIL loopback_missing: got %0d undelivered frames expected 0", load_q.size());
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1;
        en = 0;
        s_valid = 0;
        s_left = '0;
        s_right = '0;
        m_reset();
        test_reset();
        test_basic();
        test_underrun();
        test_back_to_back();
        test_stop();
        test_async_reset();
        test_random_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
